// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-access stage behind the ALU. Runs one handshaked
// word-bus transaction per load/store opcode. It does byte-lane masking,
// alignment checking, a bus timeout, zero-extended load formatting and
// ll link-reservation tracking.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] ALU_result,
  input  logic [31:0] rt_content,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_error,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        link_valid,
  output logic [29:0] link_addr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LL  = 6'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [5:0]       op_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW, OP_LW, OP_LBU, OP_LHU, OP_LL: is_mem_op = 1'b1;
      default:                                           is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Halfword ops need an even offset, word ops a zero offset.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SH, OP_LHU:      is_misaligned = a[0];
      OP_SW, OP_LW, OP_LL: is_misaligned = (a != 2'b00);
      default:            is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [5:0] op, input logic [1:0] a);
    case (op)
      OP_SB:   lane_be = 4'b0001 << a;
      OP_SH:   lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  // Store data is replicated across lanes so the enabled lane always carries it.
  function automatic logic [31:0] lane_wdata(input logic [5:0] op, input logic [31:0] rt);
    case (op)
      OP_SB:   lane_wdata = {4{rt[7:0]}};
      OP_SH:   lane_wdata = {2{rt[15:0]}};
      default: lane_wdata = rt;
    endcase
  endfunction

  function automatic logic [31:0] format_load(input logic [5:0] op, input logic [1:0] a,
                                              input logic [31:0] rdata);
    case (op)
      OP_LBU: begin
        case (a)
          2'd0:    format_load = {24'b0, rdata[7:0]};
          2'd1:    format_load = {24'b0, rdata[15:8]};
          2'd2:    format_load = {24'b0, rdata[23:16]};
          default: format_load = {24'b0, rdata[31:24]};
        endcase
      end
      OP_LHU:  format_load = a[1] ? {16'b0, rdata[31:16]} : {16'b0, rdata[15:0]};
      default: format_load = rdata;
    endcase
  endfunction

  // Transaction FSM with all outputs registered; reset aborts any bus request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_q       <= 6'd0;
      off_q      <= 2'd0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= 32'd0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'd0;
      link_valid <= 1'b0;
      link_addr  <= 30'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q       <= opcode;
            off_q      <= ALU_result[1:0];
            busy       <= 1'b1;
            addr_error <= 1'b0;
            bus_error  <= 1'b0;
            if (is_mem_op(opcode) && !is_misaligned(opcode, ALU_result[1:0])) begin
              mem_req   <= 1'b1;
              mem_we    <= is_store(opcode);
              mem_addr  <= {ALU_result[31:2], 2'b00};
              mem_be    <= lane_be(opcode, ALU_result[1:0]);
              mem_wdata <= lane_wdata(opcode, rt_content);
              cnt       <= CNT_ONE;
              state     <= REQ;
            end else begin
              // Non-memory opcodes finish without error; misaligned ones flag it.
              addr_error <= is_mem_op(opcode);
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            // An ack always wins, even in the last allowed cycle.
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
            if (!mem_we) begin
              load_data <= format_load(op_q, off_q, mem_rdata);
            end
            if (op_q == OP_LL) begin
              link_valid <= 1'b1;
              link_addr  <= mem_addr[31:2];
            end else if (mem_we && (mem_addr[31:2] == link_addr)) begin
              link_valid <= 1'b0;
            end
          end else if (cnt == CNT_MAX) begin
            mem_req   <= 1'b0;
            bus_error <= 1'b1;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed and randomized transactions,
// a bus responder, and a scoreboard fed by a reference model of the
// load/store, alignment, timeout and link rules.
module tb_mem_access_unit;

  localparam int TIMEOUT = 4;

  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2b;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] LL  = 6'h30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [31:0] ALU_result = 32'd0;
  logic [31:0] rt_content = 32'd0;
  logic        busy, done, addr_error, bus_error, mem_req, mem_we, link_valid;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [29:0] link_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .ALU_result(ALU_result), .rt_content(rt_content), .busy(busy), .done(done),
    .load_data(load_data), .addr_error(addr_error), .bus_error(bus_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .link_valid(link_valid), .link_addr(link_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    int          start_cyc;
    int          lat;
    int          reqcyc;
    bit          addr_err;
    bit          bus_err;
    bit          chk_load;
    logic [31:0] load;
    bit          link_v;
    logic [29:0] link_a;
  } exp_t;

  exp_t sb_q[$];

  // expected bus fields of the transaction in flight
  logic [31:0] cur_addr = 0, cur_wdata = 0;
  logic [3:0]  cur_be = 0;
  logic        cur_we = 0;
  // responder plan
  int          plan_wait = 0;
  bit          plan_noack = 1;
  logic [31:0] plan_rdata = 0;
  // reference model state
  bit          m_link_v = 0;
  logic [29:0] m_link_a = 0;
  logic [31:0] m_last_load = 0;

  // Bus responder: acks on REQ cycle plan_wait+1 (or never); random acks outside REQ.
  int rq_n = 0;
  always @(negedge clk) begin
    if (mem_req === 1'b1) begin
      rq_n++;
      mem_ack   = !plan_noack && (rq_n == plan_wait + 1);
      mem_rdata = mem_ack ? plan_rdata : $urandom;
    end else begin
      rq_n      = 0;
      mem_ack   = ($urandom_range(3, 0) == 0);
      mem_rdata = $urandom;
    end
  end

  // Monitor: checks bus fields every REQ cycle and pops the scoreboard on done.
  int   req_seen = 0;
  exp_t me;
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      req_seen = 0;
    end else begin
      if (mem_req === 1'b1) begin
        req_seen++;
        chk("bus_fields", {mem_addr, mem_be, mem_we, (mem_we ? mem_wdata : 32'd0)},
            {cur_addr, cur_be, cur_we, (cur_we ? cur_wdata : 32'd0)});
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d, required none", cyc);
        end else begin
          me = sb_q.pop_front();
          chk("done_latency", 96'(cyc - me.start_cyc), 96'(me.lat));
          chk("req_cycles", 96'(req_seen), 96'(me.reqcyc));
          chk("error_flags", {addr_error, bus_error}, {me.addr_err, me.bus_err});
          chk("busy_with_done", busy, 1'b1);
          if (me.chk_load) chk("load_data", load_data, me.load);
          chk("link", {link_valid, link_addr}, {me.link_v, me.link_a});
        end
        req_seen = 0;
      end
    end
  end

  function automatic bit is_store_op(input logic [5:0] op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic bit is_load_op(input logic [5:0] op);
    return (op == LW) || (op == LBU) || (op == LHU) || (op == LL);
  endfunction

  // Model one transaction, arm the responder, issue start, and wait (bounded) for done.
  task automatic do_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] rdata, input int w);
    exp_t e;
    logic [1:0] a;
    bit mem, mis, go, ack;
    logic [3:0] be;
    a   = addr[1:0];
    mem = is_store_op(op) || is_load_op(op);
    mis = ((op == SH || op == LHU) && a[0]) || ((op == SW || op == LW || op == LL) && a != 2'b00);
    go  = mem && !mis;
    ack = go && (w < TIMEOUT);
    e.lat      = !go ? 1 : (ack ? w + 2 : TIMEOUT + 1);
    e.reqcyc   = !go ? 0 : (ack ? w + 1 : TIMEOUT);
    e.addr_err = mis;
    e.bus_err  = go && !ack;
    e.chk_load = !mem;
    if (ack && is_load_op(op)) begin
      if (op == LBU)      m_last_load = (rdata >> (8 * int'(a))) & 32'hFF;
      else if (op == LHU) m_last_load = (rdata >> (a[1] ? 16 : 0)) & 32'hFFFF;
      else                m_last_load = rdata;
      e.chk_load = 1;
    end
    e.load = m_last_load;
    if (ack) begin
      if (op == LL) begin
        m_link_v = 1;
        m_link_a = addr[31:2];
      end else if (is_store_op(op) && addr[31:2] == m_link_a) begin
        m_link_v = 0;
      end
    end
    e.link_v = m_link_v;
    e.link_a = m_link_a;
    be = 4'b1111;
    cur_wdata = rt;
    if (op == SB) begin
      be = 4'b0000;
      be[a] = 1'b1;
      cur_wdata = {4{rt[7:0]}};
    end else if (op == SH) begin
      be = a[1] ? 4'b1100 : 4'b0011;
      cur_wdata = {2{rt[15:0]}};
    end
    @(negedge clk);
    cur_addr   = {addr[31:2], 2'b00};
    cur_be     = be;
    cur_we     = is_store_op(op);
    plan_wait  = w;
    plan_noack = (w >= TIMEOUT);
    plan_rdata = rdata;
    opcode     = op;
    ALU_result = addr;
    rt_content = rt;
    start      = 1'b1;
    e.start_cyc = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    start      = 1'b0;
    opcode     = 6'($urandom);
    ALU_result = $urandom;
    rt_content = $urandom;
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      if (busy === 1'b1 && $urandom_range(3, 0) == 0) begin
        start      = 1'b1;
        opcode     = SW;
        ALU_result = {m_link_a, 2'b00};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (sb_q.size() != 0) begin
      n_checks++;
      $display("FAIL done_wait: got no done within 40 cycles, required done");
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  logic [5:0] ops [10] = '{SB, SH, SW, LW, LBU, LHU, LL, 6'h00, 6'h0f, 6'h2a};

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, addr_error, bus_error, mem_req, mem_we, link_valid}, 7'b0);
    chk("reset_data", {load_data, mem_addr, mem_wdata}, 96'd0);
    chk("reset_be_link", {mem_be, link_addr}, 34'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed cases
    do_txn(LW,  32'h100, 32'h0, 32'hDEADBEEF, 0);
    do_txn(SB,  32'h203, 32'h000000A5, 32'h0, 1);
    do_txn(LBU, 32'h302, 32'h0, 32'h11223344, 0);
    do_txn(LHU, 32'h302, 32'h0, 32'h11223344, 2);
    do_txn(LW,  32'h101, 32'h0, 32'h0, 0);
    do_txn(LHU, 32'h303, 32'h0, 32'h0, 0);
    do_txn(SH,  32'h201, 32'h1234, 32'h0, 0);
    do_txn(6'h00, 32'h100, 32'h0, 32'h0, 0);
    do_txn(LW,  32'h500, 32'h0, 32'hCAFEF00D, TIMEOUT);
    do_txn(LW,  32'h500, 32'h0, 32'hCAFEF00D, TIMEOUT - 1);
    do_txn(LL,  32'h400, 32'h0, 32'h55AA55AA, 0);
    do_txn(SW,  32'h404, 32'h87654321, 32'h0, 1);
    do_txn(SH,  32'h402, 32'h0000BEEF, 32'h0, 0);
    do_txn(LL,  32'h400, 32'h0, 32'h01020304, 0);
    do_txn(SB,  32'h401, 32'h0, 32'h0, TIMEOUT);

    // randomized transactions around a small window of words
    for (int n = 0; n < 250; n++) begin
      do_txn(ops[$urandom_range(9, 0)],
             ((32'h100 + $urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0)),
             $urandom, $urandom, $urandom_range(TIMEOUT, 0));
    end

    // reset during REQ after an ll: request drops, link cleared, no done
    do_txn(LL, 32'h400, 32'h0, 32'h0, 0);
    @(negedge clk);
    cur_addr = 32'h600; cur_be = 4'b1111; cur_we = 1'b0; plan_noack = 1;
    opcode = LW; ALU_result = 32'h600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("req_before_reset", mem_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_req", {mem_req, done, busy, link_valid}, 4'b0000);
    rst_n = 1'b1;
    m_link_v = 0; m_link_a = 0; m_last_load = 0;
    repeat (4) @(negedge clk);
    do_txn(LBU, 32'h103, 32'h0, 32'h9ABCDEF0, 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage directly downstream of the 32-bit ALU. It takes the ALU's computed effective address plus the store data for MIPS load/store opcodes (sb, sh, sw, lw, lbu, lhu, ll). It runs one handshaked word-bus transaction per instruction with byte-lane masking, alignment checking and a bus timeout. It returns zero-extended load data and tracks the ll link reservation.

## Interface
- TIMEOUT, 16: max REQ cycles without `mem_ack` before abort (≥1).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request strobe; accepted only when `busy`=0.
- `opcode` in 6: instruction opcode (sb 0x28, sh 0x29, sw 0x2b, lw 0x23, lbu 0x24, lhu 0x25, ll 0x30).
- `ALU_result` in 32: effective address from ALU.
- `rt_content` in 32: store data.
- `busy` out 1: transaction in progress (REQ or DONE state).
- `done` out 1: one-cycle completion pulse.
- `load_data` out 32: load result, valid when `done`=1.
- `addr_error` out 1: misaligned access; valid with `done`.
- `bus_error` out 1: timeout abort; valid with `done`.
- `mem_req` out 1: bus request, held until ack or abort.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, `{ALU_result[31:2],2'b00}`.
- `mem_be` out 4: byte enables, bit i = bits 8i+7:8i.
- `mem_wdata` out 32: write data, lane-replicated.
- `mem_ack` in 1: transaction complete this cycle.
- `mem_rdata` in 32: read data, valid with `mem_ack`.
- `link_valid` out 1: ll reservation active.
- `link_addr` out 30: reserved word address `[31:2]`.

## Operation
- FSM states: IDLE, REQ, DONE. Reset → IDLE.
- IDLE, `start`=1: latch opcode, address, rt_content, byte offset `a = ALU_result[1:0]`.
  - Memory opcode, aligned → REQ.
  - Misaligned (sh/lhu with a[0]=1; sw/lw/ll with a≠0) → DONE with `addr_error`=1, no bus access.
  - Non-memory opcode → DONE, no bus access, no error, `load_data` holds its previous value.
- Little-endian lanes:
  - sb: be = 1<<a, wdata = {4{rt[7:0]}}.
  - sh: be = a[1] ? 1100 : 0011, wdata = {2{rt[15:0]}}.
  - sw: be = 1111, wdata = rt.
  - Loads: be = 1111, mem_we = 0.
- Load formatting:
  - lbu: `{24'b0, byte a of rdata}`.
  - lhu: `{16'b0, half a[1] of rdata}`.
  - lw/ll: rdata.
- REQ:
  - `mem_req`=1 with stable addr/be/wdata/we.
  - Timeout counter starts at 1 on entry and increments each REQ cycle.
  - `mem_ack`=1 → capture data, → DONE.
  - Counter reaches TIMEOUT with no ack → drop `mem_req`, → DONE with `bus_error`=1.
  - Ack in the TIMEOUT-th cycle wins: no error.
- DONE: `done`=1 for one cycle, → IDLE. Error flags are cleared on the next accepted start.
- Link reservation:
  - Successful ll sets `link_valid`=1 and `link_addr`=addr[31:2]. A new ll overwrites it.
  - Successful store (ack, no error) whose word address equals `link_addr` clears `link_valid`.
  - Errored or aborted transactions leave the link unchanged.
- `start` while `busy`=1 is ignored. No queuing.

## Timing
- All outputs registered. Reset values: `busy`, `done`, `addr_error`, `bus_error`, `mem_req`, `mem_we`, `link_valid` = 0; `mem_be` = 0000; `load_data`, `mem_addr`, `mem_wdata`, `link_addr` = 0.
- `start` sampled at edge k:
  - Aligned memory op: `mem_req`=1 from cycle k+1.
  - Zero-wait ack, sampled at edge k+2: `done` in cycle k+2.
  - Each wait cycle adds 1.
- Misaligned or non-memory: `done` in cycle k+1.
- Timeout: `mem_req` high for exactly TIMEOUT cycles, `done` in the following cycle.
- `busy` is high from cycle k+1 through the `done` cycle inclusive. A new `start` may be accepted in the cycle after `done`.
- `mem_ack` outside REQ is ignored.
- `rst_n`=0 mid-transaction: at the next edge `mem_req` drops and the FSM goes to IDLE. No `done` pulse; link cleared.

## Test plan
- lw at 0x100, `mem_rdata`=0xDEADBEEF, ack on the first REQ cycle → `mem_be`=1111, `done` 2 cycles after start, `load_data`=0xDEADBEEF.
- sb at 0x203, rt=0x000000A5 → `mem_addr`=0x200, `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_we`=1.
- Loads from 0x302 with `mem_rdata`=0x11223344:
  - lbu → 0x00000022.
  - lhu → 0x00001122.
- lw at 0x101 → `done`+`addr_error` 1 cycle after start, `mem_req` never asserted.
- TIMEOUT=4, ack never arrives → `mem_req` high for exactly 4 cycles, then `done`+`bus_error`. Repeat with ack in cycle 4 → no error.
- Link tracking:
  - ll at 0x400 → `link_valid`=1, `link_addr`=0x100.
  - sw at 0x404 → link kept.
  - sh at 0x402 → link cleared.
  - ll followed by `rst_n` low during a later REQ → `link_valid`=0, no `done`.
